// File: rtl/myip.sv
`timescale 1ns/1ps
// myip -- UART block-sum engine.
//
// Receives NUM_IN_BYTES serial bytes (8N1) on uart_txd_in and sums each run
// of NUM_IN_BYTES/NUM_OUT_BYTES consecutive bytes modulo 256. Once a frame
// is complete it sends the NUM_OUT_BYTES sums back-to-back on uart_rxd_out,
// then waits for the next frame.
//
// Parameters
//   CLKS_PER_BIT   sysclk cycles per UART bit (>= 2)
//   NUM_IN_BYTES   bytes received per frame (integer multiple of NUM_OUT_BYTES)
//   NUM_OUT_BYTES  result bytes transmitted per frame
//
// Ports
//   sysclk        in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   uart_txd_in   in   serial input, idle high, asynchronous to sysclk
//   uart_rxd_out  out  serial output, idle high, registered
//
// Build option
//   MYIP_FRAME_CHECK_EN  when defined, a byte whose stop bit samples low is
//                        dropped and the receiver waits for the line to go
//                        high before it looks for the next start bit. When
//                        undefined, the stop bit is ignored.
module myip #(
    parameter int CLKS_PER_BIT  = 1250,
    parameter int NUM_IN_BYTES  = 3072,
    parameter int NUM_OUT_BYTES = 32
) (
    input  logic sysclk,
    input  logic rst_n,
    input  logic uart_txd_in,
    output logic uart_rxd_out
);

    localparam int BLK_BYTES = NUM_IN_BYTES / NUM_OUT_BYTES;
    localparam int CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int POS_W     = (BLK_BYTES > 1) ? $clog2(BLK_BYTES) : 1;
    localparam int IDX_W     = (NUM_OUT_BYTES > 1) ? $clog2(NUM_OUT_BYTES) : 1;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [POS_W-1:0] POS_LAST  = POS_W'(BLK_BYTES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_OUT_BYTES - 1);

    // Block sums wrap; the carry out of bit 7 is intentionally discarded.
    function automatic logic [7:0] add_mod256(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction

    typedef enum logic {ST_RECEIVE, ST_TRANSMIT} top_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    top_state_t top_state, top_next;
    logic       accept;
    logic       enter_tx;
    logic       tx_done;

    // ---- input synchronizer (p0, p1) and edge history ----
    logic sync_p0, sync_p1, rx_prev;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync_p0 <= uart_txd_in;
            sync_p1 <= sync_p0;
            rx_prev <= sync_p1;
        end
    end

    // ---- receiver ----
    rx_state_t        rx_state, rx_next;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_shift;
    logic             rx_valid;
    logic             rx_ign;
    logic             rx_fall, rx_half, rx_full, rx_byte_done, rx_stop_ok;

    assign rx_fall      = rx_prev & ~sync_p1;
    assign rx_half      = (rx_cnt == HALF_LAST);
    assign rx_full      = (rx_cnt == BIT_LAST);
    assign rx_byte_done = (rx_state == RX_STOP) && rx_full;
`ifdef MYIP_FRAME_CHECK_EN
    assign rx_stop_ok   = sync_p1;
`else
    assign rx_stop_ok   = 1'b1;
`endif

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:      if (rx_fall) rx_next = RX_START;
            // Start bit must still be low at its centre, otherwise it was a glitch.
            RX_START:     if (rx_half) rx_next = sync_p1 ? RX_IDLE : RX_DATA;
            RX_DATA:      if (rx_full && rx_bit == 3'd7) rx_next = RX_STOP;
            RX_STOP: begin
                if (rx_full) begin
`ifdef MYIP_FRAME_CHECK_EN
                    rx_next = sync_p1 ? RX_IDLE : RX_WAIT_HIGH;
`else
                    rx_next = RX_IDLE;
`endif
                end
            end
            RX_WAIT_HIGH: if (sync_p1) rx_next = RX_IDLE;
            default:      rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_valid <= 1'b0;
            rx_ign   <= 1'b0;
        end else begin
            rx_state <= rx_next;
            rx_valid <= rx_byte_done && rx_stop_ok;
            if (rx_state == RX_IDLE || rx_state != rx_next || rx_full)
                rx_cnt <= '0;
            else
                rx_cnt <= rx_cnt + 1'b1;
            // A byte whose start edge lands in TRANSMIT (including the switch
            // cycle itself) is received normally but never delivered.
            if (rx_state == RX_IDLE && rx_fall)
                rx_ign <= (top_next == ST_TRANSMIT);
            if (rx_state == RX_START)
                rx_bit <= '0;
            if (rx_state == RX_DATA && rx_full) begin
                rx_shift <= {sync_p1, rx_shift[7:1]};
                rx_bit   <= rx_bit + 3'd1;
            end
        end
    end

    // ---- frame accumulation and top-level FSM ----
    logic [7:0]       acc;
    logic [POS_W-1:0] blk_pos;
    logic [IDX_W-1:0] blk_idx;
    logic [7:0]       results [NUM_OUT_BYTES];

    assign accept   = rx_valid && !rx_ign && (top_state == ST_RECEIVE);
    assign enter_tx = accept && (blk_pos == POS_LAST) && (blk_idx == IDX_LAST);

    always_comb begin
        top_next = top_state;
        case (top_state)
            ST_RECEIVE:  if (enter_tx) top_next = ST_TRANSMIT;
            ST_TRANSMIT: if (tx_done)  top_next = ST_RECEIVE;
            default:     top_next = ST_RECEIVE;
        endcase
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n)
            top_state <= ST_RECEIVE;
        else
            top_state <= top_next;
    end

    // Counters wrap to zero on the frame's last byte, so the next frame
    // starts clean as soon as TRANSMIT finishes.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            blk_pos <= '0;
            blk_idx <= '0;
            for (int i = 0; i < NUM_OUT_BYTES; i++)
                results[i] <= '0;
        end else if (accept) begin
            if (blk_pos == POS_LAST) begin
                results[blk_idx] <= add_mod256(acc, rx_shift);
                acc              <= '0;
                blk_pos          <= '0;
                blk_idx          <= (blk_idx == IDX_LAST) ? '0 : blk_idx + 1'b1;
            end else begin
                acc     <= add_mod256(acc, rx_shift);
                blk_pos <= blk_pos + 1'b1;
            end
        end
    end

    // ---- transmitter ----
    tx_state_t        tx_state, tx_next;
    logic [CNT_W-1:0] tx_cnt;
    logic [2:0]       tx_bit;
    logic [7:0]       tx_shift;
    logic [7:0]       tx_cur;
    logic [IDX_W-1:0] tx_sel;
    logic             tx_line;
    logic             tx_full;

    assign tx_full      = (tx_cnt == BIT_LAST);
    assign tx_cur       = results[tx_sel];
    assign tx_done      = (tx_state == TX_STOP) && tx_full && (tx_sel == IDX_LAST);
    assign uart_rxd_out = tx_line;

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE:  if (enter_tx) tx_next = TX_START;
            TX_START: if (tx_full) tx_next = TX_DATA;
            TX_DATA:  if (tx_full && tx_bit == 3'd7) tx_next = TX_STOP;
            TX_STOP:  if (tx_full) tx_next = (tx_sel == IDX_LAST) ? TX_IDLE : TX_START;
            default:  tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_sel   <= '0;
            tx_line  <= 1'b1;
        end else begin
            tx_state <= tx_next;
            if (tx_state == TX_IDLE || tx_full)
                tx_cnt <= '0;
            else
                tx_cnt <= tx_cnt + 1'b1;
            case (tx_state)
                TX_IDLE: begin
                    if (enter_tx) begin
                        tx_line <= 1'b0;
                        tx_sel  <= '0;
                    end
                end
                // The result byte is fetched at the end of the start bit, by
                // which time the last block's sum is already in the file.
                TX_START: begin
                    if (tx_full) begin
                        tx_line  <= tx_cur[0];
                        tx_shift <= tx_cur >> 1;
                        tx_bit   <= '0;
                    end
                end
                TX_DATA: begin
                    if (tx_full) begin
                        if (tx_bit == 3'd7) begin
                            tx_line <= 1'b1;
                        end else begin
                            tx_line  <= tx_shift[0];
                            tx_shift <= tx_shift >> 1;
                            tx_bit   <= tx_bit + 3'd1;
                        end
                    end
                end
                TX_STOP: begin
                    if (tx_full) begin
                        if (tx_sel == IDX_LAST) begin
                            tx_sel <= '0;
                        end else begin
                            tx_line <= 1'b0;
                            tx_sel  <= tx_sel + 1'b1;
                        end
                    end
                end
                default: tx_line <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_myip.sv
`timescale 1ns/1ps
module tb_myip;

    localparam int CPB  = 8;
    localparam int NIN  = 12;
    localparam int NOUT = 4;
    localparam int BLK  = NIN / NOUT;

    logic sysclk      = 1'b0;
    logic rst_n       = 1'b0;
    logic uart_txd_in = 1'b1;
    logic uart_rxd_out;

    myip #(
        .CLKS_PER_BIT (CPB),
        .NUM_IN_BYTES (NIN),
        .NUM_OUT_BYTES(NOUT)
    ) dut (
        .sysclk      (sysclk),
        .rst_n       (rst_n),
        .uart_txd_in (uart_txd_in),
        .uart_rxd_out(uart_rxd_out)
    );

    always #1 sysclk = ~sysclk;

    int unsigned cyc = 0;
    always @(posedge sysclk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  exp_q [$];
    logic [7:0]  got_q [$];
    int unsigned got_t [$];

    int          m_cnt    = 0;
    logic [7:0]  m_acc    = 8'h00;
    bit          m_busy   = 1'b0;
    int unsigned trig_cyc = 0;
    bit          mon_en   = 1'b0;

    // Serial decoder on the DUT output; records each byte and its start cycle.
    initial begin
        wait (mon_en);
        forever begin
            @(negedge sysclk);
            if (rst_n && uart_rxd_out === 1'b0) begin
                int unsigned t0;
                logic [7:0]  b;
                t0 = cyc;
                repeat (CPB/2) @(negedge sysclk);
                n_vec++;
                if (uart_rxd_out !== 1'b0) begin
                    n_err++;
                    $display("FAIL tx_start_bit: got %b, want 0 (start cycle %0d)", uart_rxd_out, t0);
                end
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge sysclk);
                    b[i] = uart_rxd_out;
                end
                repeat (CPB) @(negedge sysclk);
                n_vec++;
                if (uart_rxd_out !== 1'b1) begin
                    n_err++;
                    $display("FAIL tx_stop_bit: got %b, want 1 (start cycle %0d)", uart_rxd_out, t0);
                end
                got_q.push_back(b);
                got_t.push_back(t0);
            end
        end
    end

    initial begin
        repeat (80000) @(posedge sysclk);
        n_err++;
        $display("FAIL watchdog: simulation still running at cycle %0d, want finished", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog expired");
    end

    // Reference model: block sums pushed as each block's last byte is sent.
    task automatic model_byte(input logic [7:0] b, input int unsigned stop_mid);
        if (m_busy) return;
        m_acc = m_acc + b;
        m_cnt++;
        if (m_cnt % BLK == 0) begin
            exp_q.push_back(m_acc);
            m_acc = 8'h00;
        end
        if (m_cnt == NIN) begin
            m_busy   = 1'b1;
            m_cnt    = 0;
            trig_cyc = stop_mid;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_val = 1'b1);
        int unsigned stop_mid;
        bit          counted;
        @(negedge sysclk);
        uart_txd_in = 1'b0;
        repeat (CPB) @(negedge sysclk);
        for (int i = 0; i < 8; i++) begin
            uart_txd_in = b[i];
            repeat (CPB) @(negedge sysclk);
        end
        uart_txd_in = stop_val;
        stop_mid = cyc + CPB/2;
        repeat (CPB) @(negedge sysclk);
        if (!stop_val) begin
            uart_txd_in = 1'b1;
            repeat (2*CPB) @(negedge sysclk);
        end
        counted = 1'b1;
`ifdef MYIP_FRAME_CHECK_EN
        counted = stop_val;
`endif
        if (counted) model_byte(b, stop_mid);
    endtask

    task automatic send_frame(input logic [7:0] v);
        for (int i = 0; i < NIN; i++) send_byte(v);
    endtask

    // Collects NOUT output bytes, checks values, first-start latency and
    // back-to-back spacing, then lets the DUT return to RECEIVE.
    task automatic check_frame(input string name);
        int unsigned prev_t;
        prev_t = 0;
        for (int k = 0; k < NOUT; k++) begin
            int          guard;
            logic [7:0]  got;
            logic [7:0]  want;
            int unsigned t;
            guard = 0;
            want  = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            while (got_q.size() == 0 && guard < 40*CPB) begin
                @(negedge sysclk);
                guard++;
            end
            n_vec++;
            if (got_q.size() == 0) begin
                n_err++;
                $display("FAIL %s_timeout[%0d]: got no byte, want %h", name, k, want);
                continue;
            end
            got = got_q.pop_front();
            t   = got_t.pop_front();
            if (got !== want) begin
                n_err++;
                $display("FAIL %s_value[%0d]: got %h, want %h", name, k, got, want);
            end
            n_vec++;
            if (k == 0) begin
                if (t < trig_cyc || t > trig_cyc + 10) begin
                    n_err++;
                    $display("FAIL %s_latency: start at cycle %0d, want within [%0d,%0d]",
                             name, t, trig_cyc, trig_cyc + 10);
                end
            end else if (t - prev_t != 10*CPB) begin
                n_err++;
                $display("FAIL %s_spacing[%0d]: got %0d cycles, want %0d", name, k, t - prev_t, 10*CPB);
            end
            prev_t = t;
        end
        repeat (2*CPB) @(negedge sysclk);
        m_busy = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge sysclk);
        for (int i = 0; i < 4; i++) begin
            @(negedge sysclk);
            n_vec++;
            if (uart_rxd_out !== 1'b1) begin
                n_err++;
                $display("FAIL reset_line: got %b, want 1", uart_rxd_out);
            end
        end
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (4*CPB) @(negedge sysclk);
        n_vec++;
        if (got_q.size() != 0 || uart_rxd_out !== 1'b1) begin
            n_err++;
            $display("FAIL reset_idle: got %0d bytes line %b, want 0 bytes line 1", got_q.size(), uart_rxd_out);
        end
    endtask

    task automatic test_sum_ones;
        send_frame(8'h01);
        check_frame("ones");
    endtask

    task automatic test_wrap_second_frame;
        send_frame(8'hFF);
        check_frame("ff_wrap");
        send_frame(8'h80);
        check_frame("x80_wrap");
    endtask

    task automatic test_block_pattern;
        for (int i = 0; i < NIN; i++) send_byte(8'(i / BLK));
        check_frame("block_k");
        for (int i = 0; i < NIN; i++) send_byte(8'($urandom_range(0, 255)));
        check_frame("random");
    endtask

    task automatic test_glitch;
        @(negedge sysclk);
        uart_txd_in = 1'b0;
        repeat (2) @(negedge sysclk);
        uart_txd_in = 1'b1;
        repeat (3*CPB) @(negedge sysclk);
        send_frame(8'h01);
        check_frame("after_glitch");
    endtask

    task automatic test_discard;
        send_frame(8'h01);
        send_byte(8'h40);
        send_byte(8'h40);
        check_frame("pre_discard");
        send_frame(8'h02);
        check_frame("post_discard");
    endtask

    task automatic test_reset_mid_frame;
        for (int i = 0; i < 5; i++) send_byte(8'h01);
        @(negedge sysclk);
        uart_txd_in = 1'b0;
        repeat (3*CPB) @(negedge sysclk);
        uart_txd_in = 1'b1;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge sysclk);
            n_vec++;
            if (uart_rxd_out !== 1'b1) begin
                n_err++;
                $display("FAIL midreset_line: got %b, want 1", uart_rxd_out);
            end
        end
        rst_n = 1'b1;
        m_cnt = 0;
        m_acc = 8'h00;
        exp_q.delete();
        repeat (3*CPB) @(negedge sysclk);
        n_vec++;
        if (got_q.size() != 0 || uart_rxd_out !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_quiet: got %0d bytes line %b, want 0 bytes line 1", got_q.size(), uart_rxd_out);
        end
        send_frame(8'h01);
        check_frame("after_reset");
    endtask

    task automatic test_frame_check;
        send_byte(8'h05, 1'b0);
        send_frame(8'h01);
        check_frame("stop_err");
    endtask

    initial begin
        test_reset();
        test_sum_ones();
        test_wrap_second_frame();
        test_block_pattern();
        test_glitch();
        test_discard();
        test_reset_mid_frame();
        test_frame_check();
        repeat (4*CPB) @(negedge sysclk);
        n_vec++;
        if (got_q.size() != 0) begin
            n_err++;
            $display("FAIL stray_output: got %0d extra bytes, want 0", got_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
